// File: rtl/timer_sequencer_host.sv
// timer_sequencer_host
//
// Command-driven sequencer for a timer host. It accepts a "wait N timeout
// periods" command, then for each period pulses start_timer, waits for the
// timer to report running, waits for timeout_flag and pulses clear_timeout.
// When all periods are counted it pulses done. While the timer runs it also
// checks for three failures: the timer never starts, timer_count stops
// advancing, or a period runs too long. Each failure ends the command with
// err set.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_periods         number of periods to wait (0 is treated as 1)
//   abort               cancel the active command (ignored in IDLE)
//   start_timer         to timer host: restart the timer
//   pause_timer         to timer host: stop the timer (abort only)
//   clear_timeout       to timer host: clear timeout_flag
//   timer_count         from timer host: current count
//   timeout_flag        from timer host: period elapsed
//   timer_running       from timer host: timer is counting
//   busy                state is not IDLE
//   done                one-cycle completion pulse
//   periods_done        timeouts counted for the current/last command
//   err, err_code       sticky error and cause (01 no-run, 10 stall, 11 watchdog)
module timer_sequencer_host #(
  parameter int TIMER_WIDTH  = 10,
  parameter int PERIOD_WIDTH = 8,
  parameter int RUN_WAIT_MAX = 4,
  parameter int STALL_LIMIT  = 4,
  parameter int WDOG_LIMIT   = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PERIOD_WIDTH-1:0] cmd_periods,
  input  logic                    abort,
  output logic                    start_timer,
  output logic                    pause_timer,
  output logic                    clear_timeout,
  input  logic [TIMER_WIDTH-1:0]  timer_count,
  input  logic                    timeout_flag,
  input  logic                    timer_running,
  output logic                    busy,
  output logic                    done,
  output logic [PERIOD_WIDTH-1:0] periods_done,
  output logic                    err,
  output logic [1:0]              err_code
);

  localparam int WAIT_W  = $clog2(RUN_WAIT_MAX) + 1;
  localparam int STALL_W = $clog2(STALL_LIMIT) + 1;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_NORUN = 2'b01;
  localparam logic [1:0] CODE_STALL = 2'b10;
  localparam logic [1:0] CODE_WDOG  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_RUN,
    S_RUN,
    S_CLEAR,
    S_DONE,
    S_ABORT
  } state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] target;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [STALL_W-1:0]      stall_cnt;
  logic [15:0]             wdog_cnt;
  logic [TIMER_WIDTH-1:0]  count_prev;
  logic                    count_same;

  // Outputs depend on the state register only, so the timer host never sees
  // a combinational path from any of our inputs.
  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign start_timer   = (state == S_START);
  assign clear_timeout = (state == S_CLEAR) || (state == S_ABORT);
  assign pause_timer   = (state == S_ABORT);
  assign done          = (state == S_DONE);

  assign count_same = (timer_count == count_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      target       <= '0;
      wait_cnt     <= '0;
      stall_cnt    <= '0;
      wdog_cnt     <= '0;
      count_prev   <= '0;
      periods_done <= '0;
      err          <= 1'b0;
      err_code     <= CODE_NONE;
    end else begin
      // Previous-cycle count, used to detect a stalled timer.
      count_prev <= timer_count;

      // Abort wins over everything. ABORT itself always returns to IDLE so
      // the pause/clear pulse lasts exactly one cycle even if abort is held.
      if (abort && (state != S_IDLE) && (state != S_ABORT)) begin
        state <= S_ABORT;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              target       <= (cmd_periods == '0) ? PERIOD_WIDTH'(1) : cmd_periods;
              periods_done <= '0;
              err          <= 1'b0;
              err_code     <= CODE_NONE;
              state        <= S_START;
            end
          end

          S_START: begin
            wait_cnt <= '0;
            state    <= S_WAIT_RUN;
          end

          S_WAIT_RUN: begin
            if (timer_running) begin
              stall_cnt <= '0;
              wdog_cnt  <= '0;
              state     <= S_RUN;
            end else if (wait_cnt == WAIT_W'(RUN_WAIT_MAX - 1)) begin
              err      <= 1'b1;
              err_code <= CODE_NORUN;
              state    <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end

          S_RUN: begin
            if (timeout_flag) begin
              if (periods_done != '1) begin
                periods_done <= periods_done + 1'b1;
              end
              state <= S_CLEAR;
            end else if (!timer_running ||
                         (count_same && (stall_cnt == STALL_W'(STALL_LIMIT - 1)))) begin
              err      <= 1'b1;
              err_code <= CODE_STALL;
              state    <= S_IDLE;
            end else if (wdog_cnt == 16'(WDOG_LIMIT - 1)) begin
              err      <= 1'b1;
              err_code <= CODE_WDOG;
              state    <= S_IDLE;
            end else begin
              wdog_cnt  <= wdog_cnt + 1'b1;
              stall_cnt <= count_same ? stall_cnt + 1'b1 : '0;
            end
          end

          S_CLEAR: begin
            state <= (periods_done == target) ? S_DONE : S_START;
          end

          S_DONE:  state <= S_IDLE;
          S_ABORT: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
